// File: rtl/hospital_rover_pkg.sv
// Shared types and helpers for the hospital rover router: FSM states,
// direction encoding and loop-route shortest-path selection.
package hospital_rover_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PATROL = 2'd1,
        S_SEEK   = 2'd2,
        S_DWELL  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // On a loop of n locations, go up unless going down is strictly shorter.
    function automatic logic shortest_dir(input int cur, input int tgt, input int n);
        int up_dist;
        up_dist = tgt - cur;
        if (up_dist < 0) begin
            up_dist = up_dist + n;
        end
        return (2 * up_dist <= n) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/rover_next_loc.sv
// Combinational one-step move of the rover along a loop route or a
// ping-pong corridor; used for both patrol and seek stepping.
module rover_next_loc
    import hospital_rover_pkg::*;
#(
    parameter int NUM_LOCS = 5,
    parameter int LOC_W    = 3,
    parameter int WRAP     = 1
) (
    input  logic [LOC_W-1:0] current_loc,
    input  logic             direction,
    output logic [LOC_W-1:0] next_loc,
    output logic             next_dir
);

    localparam logic [LOC_W-1:0] LAST = LOC_W'(NUM_LOCS - 1);
    localparam logic [LOC_W-1:0] ONE  = LOC_W'(1);

    always_comb begin
        next_loc = current_loc;
        next_dir = direction;
        if (direction == DIR_UP) begin
            if (current_loc >= LAST) begin
                if (WRAP != 0) begin
                    next_loc = '0;
                end else begin
                    next_loc = LAST - ONE;
                    next_dir = DIR_DOWN;
                end
            end else begin
                next_loc = current_loc + ONE;
            end
        end else begin
            if (current_loc == '0) begin
                if (WRAP != 0) begin
                    next_loc = LAST;
                end else begin
                    next_loc = ONE;
                    next_dir = DIR_UP;
                end
            end else begin
                next_loc = current_loc - ONE;
            end
        end
    end

endmodule

// File: rtl/hospital_rover_router.sv
// Rover controller: free patrol under move_switch, or call-driven seek to a
// requested location followed by a fixed dwell.
module hospital_rover_router
    import hospital_rover_pkg::*;
#(
    parameter int NUM_LOCS     = 5,
    parameter int LOC_W        = 3,
    parameter int DWELL_CYCLES = 3,
    parameter int WRAP         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_switch,
    input  logic             call_valid,
    input  logic [LOC_W-1:0] call_loc,
    output logic             call_ready,
    output logic [LOC_W-1:0] current_loc,
    output logic             direction,
    output logic             arrived,
    output logic             call_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [LOC_W:0]   LOC_LIMIT = (LOC_W + 1)'(NUM_LOCS);

    state_t             state_q, state_d;
    logic [LOC_W-1:0]   loc_q, loc_d;
    logic [LOC_W-1:0]   target_q, target_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               arrived_q, arrived_d;
    logic               err_q, err_d;
    logic [LOC_W-1:0]   step_loc;
    logic               step_dir;
    logic               seek_dir;
    logic               accept;

    rover_next_loc #(
        .NUM_LOCS (NUM_LOCS),
        .LOC_W    (LOC_W),
        .WRAP     (WRAP)
    ) u_next_loc (
        .current_loc (loc_q),
        .direction   (dir_q),
        .next_loc    (step_loc),
        .next_dir    (step_dir)
    );

    // Handshake: a call is taken on call_valid & call_ready; call_ready is a
    // pure decode of the state register (high only in IDLE and PATROL).
    assign call_ready  = (state_q == S_IDLE) || (state_q == S_PATROL);
    assign busy        = (state_q == S_SEEK) || (state_q == S_DWELL);
    assign current_loc = loc_q;
    assign direction   = dir_q;
    assign arrived     = arrived_q;
    assign call_err    = err_q;
    assign accept      = call_valid && call_ready;

    always_comb begin
        if (WRAP != 0) begin
            seek_dir = shortest_dir(int'(loc_q), int'(call_loc), NUM_LOCS);
        end else begin
            seek_dir = (call_loc > loc_q) ? DIR_UP : DIR_DOWN;
        end
    end

    always_comb begin
        state_d   = state_q;
        loc_d     = loc_q;
        dir_d     = dir_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        arrived_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE, S_PATROL: begin
                if (accept) begin
                    if ({1'b0, call_loc} >= LOC_LIMIT) begin
                        err_d = 1'b1;
                    end else if (call_loc == loc_q) begin
                        arrived_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_DWELL;
                    end else begin
                        target_d = call_loc;
                        dir_d    = seek_dir;
                        state_d  = S_SEEK;
                    end
                end else if (move_switch) begin
                    loc_d   = step_loc;
                    dir_d   = step_dir;
                    state_d = S_PATROL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEEK: begin
                // Seek direction never reaches a corridor end, so step_dir is unused here.
                if (move_switch) begin
                    loc_d = step_loc;
                    if (step_loc == target_q) begin
                        arrived_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            loc_q     <= '0;
            dir_q     <= DIR_UP;
            target_q  <= '0;
            cnt_q     <= '0;
            arrived_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            loc_q     <= loc_d;
            dir_q     <= dir_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            arrived_q <= arrived_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_hospital_rover_router.sv
// Directed bench for hospital_rover_router: one loop-route instance and one
// corridor instance, each driven independently, sharing clock and reset.
module tb_hospital_rover_router;
    logic       clk;
    logic       reset;

    logic       ms_l, cv_l;
    logic [2:0] cl_l;
    logic       ready_l, dir_l, arr_l, err_l, busy_l;
    logic [2:0] loc_l;

    logic       ms_p, cv_p;
    logic [2:0] cl_p;
    logic       ready_p, dir_p, arr_p, err_p, busy_p;
    logic [2:0] loc_p;

    int n_cmp = 0;
    int n_err = 0;

    hospital_rover_router #(.NUM_LOCS(5), .LOC_W(3), .DWELL_CYCLES(3), .WRAP(1)) u_loop (
        .clk(clk), .reset(reset), .move_switch(ms_l), .call_valid(cv_l), .call_loc(cl_l),
        .call_ready(ready_l), .current_loc(loc_l), .direction(dir_l), .arrived(arr_l),
        .call_err(err_l), .busy(busy_l)
    );

    hospital_rover_router #(.NUM_LOCS(5), .LOC_W(3), .DWELL_CYCLES(3), .WRAP(0)) u_line (
        .clk(clk), .reset(reset), .move_switch(ms_p), .call_valid(cv_p), .call_loc(cl_p),
        .call_ready(ready_p), .current_loc(loc_p), .direction(dir_p), .arrived(arr_p),
        .call_err(err_p), .busy(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_loc_l[8];
        int exp_loc_p[8];
        int exp_dir_p[8];
        exp_loc_l = '{1, 2, 3, 4, 0, 1, 2, 2};
        exp_loc_p = '{1, 2, 3, 4, 3, 2, 1, 0};
        exp_dir_p = '{0, 0, 0, 0, 1, 1, 1, 1};

        reset = 1'b1;
        ms_l = 0; cv_l = 0; cl_l = 0;
        ms_p = 0; cv_p = 0; cl_p = 0;
        tick();
        tick();
        check("rst_loc", 32'(loc_l), 0);
        check("rst_dir", 32'(dir_l), 0);
        check("rst_arrived", 32'(arr_l), 0);
        check("rst_err", 32'(err_l), 0);
        check("rst_busy", 32'(busy_l), 0);
        check("rst_ready", 32'(ready_l), 1);
        check("rst_loc_line", 32'(loc_p), 0);
        reset = 1'b0;

        // Patrol: loop wraps 4->0; corridor bounces at 4 and flips direction.
        ms_l = 1; ms_p = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ms_l = 0;
            tick();
            check($sformatf("patrol_loop_loc%0d", i), 32'(loc_l), 32'(exp_loc_l[i]));
            check($sformatf("patrol_line_loc%0d", i), 32'(loc_p), 32'(exp_loc_p[i]));
            check($sformatf("patrol_line_dir%0d", i), 32'(dir_p), 32'(exp_dir_p[i]));
        end
        ms_p = 0;
        tick();
        check("line_idle_hold", 32'(loc_p), 0);

        // Loop seek 2 -> 1 goes down one step.
        cv_l = 1; cl_l = 3'd1;
        tick();
        cv_l = 0;
        check("seek21_accept_loc", 32'(loc_l), 2);
        check("seek21_dir", 32'(dir_l), 1);
        check("seek21_busy", 32'(busy_l), 1);
        check("seek21_ready", 32'(ready_l), 0);
        ms_l = 1;
        tick();
        ms_l = 0;
        check("seek21_loc", 32'(loc_l), 1);
        check("seek21_arrived", 32'(arr_l), 1);
        tick();
        check("seek21_arr_pulse", 32'(arr_l), 0);
        tick();
        check("seek21_dwell2_busy", 32'(busy_l), 1);
        tick();
        check("seek21_idle_busy", 32'(busy_l), 0);
        check("seek21_idle_ready", 32'(ready_l), 1);

        // Loop seek 1 -> 4 takes the short way down through 0.
        cv_l = 1; cl_l = 3'd4;
        tick();
        cv_l = 0;
        check("seek14_dir", 32'(dir_l), 1);
        check("seek14_accept_loc", 32'(loc_l), 1);
        ms_l = 1;
        tick();
        check("seek14_step1", 32'(loc_l), 0);
        check("seek14_no_arr", 32'(arr_l), 0);
        tick();
        ms_l = 0;
        check("seek14_step2", 32'(loc_l), 4);
        check("seek14_arrived", 32'(arr_l), 1);
        check("seek14_dwell_ready0", 32'(ready_l), 0);
        tick();
        check("seek14_dwell_ready1", 32'(ready_l), 0);
        tick();
        check("seek14_dwell_ready2", 32'(ready_l), 0);
        tick();
        check("seek14_idle_ready", 32'(ready_l), 1);
        check("seek14_idle_busy", 32'(busy_l), 0);
        check("seek14_dir_kept", 32'(dir_l), 1);

        // Out-of-range call.
        cv_l = 1; cl_l = 3'd6;
        tick();
        cv_l = 0;
        check("err_pulse", 32'(err_l), 1);
        check("err_loc", 32'(loc_l), 4);
        check("err_busy", 32'(busy_l), 0);
        check("err_ready", 32'(ready_l), 1);
        tick();
        check("err_pulse_end", 32'(err_l), 0);

        // Same-location call: arrive at once, dwell, no motion.
        cv_l = 1; cl_l = 3'd4; ms_l = 1;
        tick();
        cv_l = 0;
        check("same_arrived", 32'(arr_l), 1);
        check("same_loc", 32'(loc_l), 4);
        check("same_busy", 32'(busy_l), 1);
        tick();
        tick();
        check("same_dwell_loc", 32'(loc_l), 4);
        check("same_dwell_busy", 32'(busy_l), 1);
        ms_l = 0;
        tick();
        check("same_idle_busy", 32'(busy_l), 0);

        // Corridor seek 0 -> 3 with a two-cycle pause.
        cv_p = 1; cl_p = 3'd3;
        tick();
        cv_p = 0;
        check("line_seek_dir", 32'(dir_p), 0);
        ms_p = 1;
        tick();
        check("line_seek_s1", 32'(loc_p), 1);
        ms_p = 0;
        tick();
        check("line_pause1", 32'(loc_p), 1);
        tick();
        check("line_pause2", 32'(loc_p), 1);
        check("line_pause_busy", 32'(busy_p), 1);
        ms_p = 1;
        tick();
        check("line_seek_s2", 32'(loc_p), 2);
        check("line_seek_no_arr", 32'(arr_p), 0);
        tick();
        ms_p = 0;
        check("line_seek_s3", 32'(loc_p), 3);
        check("line_seek_arrived", 32'(arr_p), 1);
        tick();
        tick();
        tick();
        check("line_seek_idle", 32'(busy_p), 0);

        // Reset in the middle of a loop seek 4 -> 2 (down).
        cv_l = 1; cl_l = 3'd2;
        tick();
        cv_l = 0;
        check("rseek_dir", 32'(dir_l), 1);
        ms_l = 1;
        tick();
        check("rseek_step", 32'(loc_l), 3);
        ms_l = 0;
        #2;
        reset = 1'b1;
        #1;
        check("rseek_async_loc", 32'(loc_l), 0);
        check("rseek_async_busy", 32'(busy_l), 0);
        check("rseek_async_ready", 32'(ready_l), 1);
        check("rseek_async_dir", 32'(dir_l), 0);
        tick();
        reset = 1'b0;
        cv_l = 1; cl_l = 3'd2;
        tick();
        cv_l = 0;
        check("post_rst_accept_busy", 32'(busy_l), 1);
        check("post_rst_dir", 32'(dir_l), 0);
        ms_l = 1;
        tick();
        check("post_rst_s1", 32'(loc_l), 1);
        tick();
        ms_l = 0;
        check("post_rst_s2", 32'(loc_l), 2);
        check("post_rst_arrived", 32'(arr_l), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hospital_rover_router.md
# hospital_rover_router

Parametrised successor to the hospital rover controller. Tracks a rover over `NUM_LOCS` ward locations with two motion modes:
- free patrol under `move_switch`;
- call-driven seek to a requested location, then a timed dwell.

Supports a looping route or a ping-pong corridor. It sits between the nurse-station call logic and the rover drive/display outputs.

## Interface
- `NUM_LOCS`, 5, number of locations, ≥2.
- `LOC_W`, 3, location width, ≥ clog2(`NUM_LOCS`).
- `DWELL_CYCLES`, 3, cycles held at a called location, ≥1.
- `WRAP`, 1, 1 = loop route (N-1↔0 adjacent), 0 = ping-pong corridor.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `move_switch` in 1: motion enable; patrol/seek step only while high.
- `call_valid` in 1: call request.
- `call_loc` in `LOC_W`: requested location.
- `call_ready` out 1: call can be accepted.
- `current_loc` out `LOC_W`: registered rover location.
- `direction` out 1: 0 = up (increasing), 1 = down.
- `arrived` out 1: one-cycle pulse on reaching the call target.
- `call_err` out 1: one-cycle pulse when an out-of-range call is accepted.
- `busy` out 1: high in SEEK and DWELL.

## Operation
- States: IDLE, PATROL, SEEK, DWELL.
- Reset values: state IDLE, `current_loc`=0, `direction`=0, `arrived`=0, `call_err`=0, `busy`=0. Target and dwell count are cleared.
- `call_ready`=1 in IDLE and PATROL, 0 in SEEK and DWELL. A call is accepted on `call_valid & call_ready`.
- Call acceptance takes priority over patrol stepping. No step occurs in the acceptance cycle.
- IDLE transitions:
  - accepted call with `call_loc` ≥ `NUM_LOCS` → `call_err` pulse, stay IDLE;
  - accepted call with `call_loc`==`current_loc` → `arrived` pulse, go to DWELL;
  - any other accepted call → latch target, go to SEEK;
  - otherwise `move_switch`=1 → PATROL.
- PATROL:
  - each cycle with `move_switch`=1, step one location in `direction`;
  - `move_switch`=0 → IDLE, with no step that cycle;
  - calls are handled as in IDLE;
  - `WRAP`=1 route: N-1+1→0 and 0−1→N-1, `direction` unchanged;
  - `WRAP`=0 route: at N-1 going up, next step is N-2 and `direction` becomes 1; mirrored at 0.
- SEEK direction, fixed at acceptance:
  - `WRAP`=1: shortest path; a tie picks up;
  - `WRAP`=0: toward target.
- SEEK stepping:
  - one step per cycle while `move_switch`=1;
  - `move_switch`=0 pauses, holding location and target;
  - the step that lands on the target asserts `arrived` for the following cycle and enters DWELL.
- DWELL:
  - lasts exactly `DWELL_CYCLES` cycles, then IDLE;
  - `move_switch` is ignored;
  - `direction` retains its last value.
- Widths: location arithmetic is modulo `NUM_LOCS`, never modulo 2^`LOC_W`. `current_loc` never leaves 0..N-1.

## Timing
- All outputs are registered. No combinational path from inputs to outputs except `call_ready`, which is a decode of the state register.
- Patrol: a step sampled at edge k is visible on `current_loc` after edge k.
- Seek latency: call accepted at edge k, path distance d, no pauses:
  - first step at edge k+1;
  - `current_loc`==target and `arrived`=1 after edge k+d;
  - IDLE after edge k+d+`DWELL_CYCLES`.
- Each paused cycle adds one cycle to the seek latency.
- Same-location call: `arrived` is high after edge k; DWELL occupies edges k+1..k+`DWELL_CYCLES`.
- Reset asserted mid-SEEK or mid-DWELL: immediate return to reset values and the target is discarded. The first acceptance is possible at the first edge after deassertion.

## Structure
- Package `hospital_rover_pkg`:
  - state enum;
  - `DIR_UP`/`DIR_DOWN` constants;
  - a function returning the shortest direction for a loop route.
- Sub-module `rover_next_loc`: combinational.
  - Inputs: `current_loc`, `direction`, `WRAP`.
  - Outputs: next location, next direction.
  - Shared by PATROL and SEEK.
- The dwell counter, width clog2(`DWELL_CYCLES`+1), lives in the top module.

## Test plan
- N=5, `WRAP`=1, `move_switch`=1 for 7 cycles after reset → `current_loc` 1,2,3,4,0,1,2.
- N=5, `WRAP`=0, `move_switch`=1 for 8 cycles → 1,2,3,4,3,2,1,0, and `direction` flips after the 4.
- `WRAP`=1, rover at 1, call 4 → `direction`=1, sequence 0,4, `arrived` after the second step, 3 DWELL cycles with `call_ready`=0, then IDLE.
- Seek 0→3 with `move_switch` low for 2 cycles mid-route → location holds during the pause, `arrived` 2 cycles later than unpaused.
- `call_loc`=6 with N=5 → one-cycle `call_err`, `current_loc` and state unchanged.
- Call to the current location → `arrived` next cycle, no motion. `reset` asserted in the middle of SEEK → `current_loc`=0 at once, `busy`=0, `call_ready`=1.
